// File: rtl/regfile_dump_reader_if.sv
// Bundle of the dump reader's control, register-file read port and output
// stream signals.
//   master : the dump engine (drives RF_ADDR, OUT_*, BUSY, DONE, COUNT)
//   slave  : the environment (drives START, range, ABORT, RF_DATA, OUT_READY)
interface regfile_dump_reader_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  START;
    logic [ADDR_WIDTH-1:0] FIRST_ADDR;
    logic [ADDR_WIDTH-1:0] LAST_ADDR;
    logic                  ABORT;
    logic [ADDR_WIDTH-1:0] RF_ADDR;
    logic [DATA_WIDTH-1:0] RF_DATA;
    logic [DATA_WIDTH-1:0] OUT_DATA;
    logic [ADDR_WIDTH-1:0] OUT_ADDR;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic                  OUT_LAST;
    logic                  BUSY;
    logic                  DONE;
    logic [ADDR_WIDTH:0]   COUNT;

    modport master (
        input  START, FIRST_ADDR, LAST_ADDR, ABORT, RF_DATA, OUT_READY,
        output RF_ADDR, OUT_DATA, OUT_ADDR, OUT_VALID, OUT_LAST, BUSY, DONE, COUNT
    );

    modport slave (
        output START, FIRST_ADDR, LAST_ADDR, ABORT, RF_DATA, OUT_READY,
        input  RF_ADDR, OUT_DATA, OUT_ADDR, OUT_VALID, OUT_LAST, BUSY, DONE, COUNT
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Debug readout engine: walks a (possibly wrapping) register range through
// register-file read port 1 and streams each word out over valid/ready.
// Ports:
//   CLK, RST : clock, asynchronous active-low reset
//   bus      : regfile_dump_reader_if.master (control, RF read port, stream)
module regfile_dump_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                   CLK,
    input  logic                   RST,
    regfile_dump_reader_if.master  bus
);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q,  cur_addr_d;
    logic [CNT_W-1:0]      remaining_q, remaining_d;
    logic [CNT_W-1:0]      count_q,     count_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q,  out_last_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;

    logic                  handshake;
    logic                  load;
    logic [ADDR_WIDTH-1:0] span;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        handshake = out_valid_q & bus.OUT_READY;
        load      = 1'b0;
        // Modulo-2^ADDR_WIDTH distance makes wrapping ranges fall out naturally
        span      = bus.LAST_ADDR - bus.FIRST_ADDR;

        case (state_q)
            S_IDLE: begin
                if (bus.START && !bus.ABORT) begin
                    cur_addr_d  = bus.FIRST_ADDR;
                    remaining_d = {1'b0, span} + CNT_W'(1);
                    count_d     = '0;
                    busy_d      = 1'b1;
                    state_d     = S_RUN;
                end
            end

            S_RUN: begin
                count_d = count_q + CNT_W'(handshake);
                if (bus.ABORT) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    // Refill the output register whenever it is empty or draining
                    load = (remaining_q != '0) && (!out_valid_q || bus.OUT_READY);
                    if (load) begin
                        out_data_d  = bus.RF_DATA;
                        out_addr_d  = cur_addr_q;
                        out_valid_d = 1'b1;
                        out_last_d  = (remaining_q == CNT_W'(1));
                        cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
                        remaining_d = remaining_q - CNT_W'(1);
                    end else if (handshake) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_FINISH;
                    end
                end
            end

            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.RF_ADDR   = cur_addr_q;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_ADDR  = out_addr_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_LAST  = out_last_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.COUNT     = count_q;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a behavioural register file
// feeds the read port and each dump is checked against an expected word list
// built from the range rules and a shadow copy of the registers.
module tb_regfile_dump_reader;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NREG  = 32;
    localparam int          LIMIT = 400;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic CLK;
    logic RST;
    logic          we3;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd3;
    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] shadow [NREG];

    int checks;
    int errors;

    regfile_dump_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) if (we3) regs[a3] <= wd3;
    assign bus.RF_DATA = regs[bus.RF_ADDR];

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check_val("rst_rf_addr", 32'(bus.RF_ADDR), 0);
        check_val("rst_out_data", bus.OUT_DATA, 0);
        check_val("rst_out_addr", 32'(bus.OUT_ADDR), 0);
        check_val("rst_out_valid", 32'(bus.OUT_VALID), 0);
        check_val("rst_out_last", 32'(bus.OUT_LAST), 0);
        check_val("rst_busy", 32'(bus.BUSY), 0);
        check_val("rst_done", 32'(bus.DONE), 0);
        check_val("rst_count", 32'(bus.COUNT), 0);
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        @(negedge CLK);
        we3 = 1'b1; a3 = AW'(a); wd3 = d;
        shadow[a] = d;
        @(posedge CLK);
        #1 we3 = 1'b0;
    endtask

    task automatic do_start(input int first, input int last);
        @(negedge CLK);
        bus.START = 1'b1; bus.FIRST_ADDR = AW'(first); bus.LAST_ADDR = AW'(last);
        @(negedge CLK);
        bus.START = 1'b0;
        check_val("start_busy", 32'(bus.BUSY), 1);
        check_val("start_rf_addr", 32'(bus.RF_ADDR), 32'(first));
        check_val("start_valid", 32'(bus.OUT_VALID), 0);
        check_val("start_count", 32'(bus.COUNT), 0);
    endtask

    // mode: 0 ready always, 1 random ready, 2 fixed back-pressure pattern
    task automatic run_dump(input int first, input int last, input int mode,
                            input int abort_after, input bit do_we,
                            input int we_a, input logic [DW-1:0] we_d,
                            input bit poke_start);
        exp_t q[$];
        exp_t e;
        int   m, accepted, cyc, vcyc;
        bit   stall, rdy;
        logic [AW-1:0] h_a;
        logic [DW-1:0] h_d;
        logic          h_l;
        int   pat [7] = '{1, 0, 0, 1, 0, 1, 1};

        m = (((last - first) % int'(NREG)) + int'(NREG)) % int'(NREG) + 1;
        for (int k = 0; k < m; k++) begin
            e.a = AW'((first + k) % int'(NREG));
            e.d = shadow[(first + k) % int'(NREG)];
            e.l = (k == m - 1);
            q.push_back(e);
        end

        do_start(first, last);
        if (do_we) begin
            we3 = 1'b1; a3 = AW'(we_a); wd3 = we_d;
            shadow[we_a] = we_d;
        end

        accepted = 0; cyc = 0; vcyc = 0; stall = 1'b0;
        h_a = '0; h_d = '0; h_l = 1'b0;
        while (q.size() > 0 && cyc < LIMIT) begin
            if (cyc == 1) we3 = 1'b0;
            if (poke_start && cyc == 3) begin
                bus.START = 1'b1;
                bus.FIRST_ADDR = AW'($urandom_range(0, NREG - 1));
                bus.LAST_ADDR  = AW'($urandom_range(0, NREG - 1));
            end
            if (cyc == 4) bus.START = 1'b0;

            if (abort_after >= 0 && accepted == abort_after) begin
                bus.ABORT = 1'b1; bus.OUT_READY = 1'b0;
                @(negedge CLK);
                bus.ABORT = 1'b0;
                check_val("abort_valid", 32'(bus.OUT_VALID), 0);
                check_val("abort_last", 32'(bus.OUT_LAST), 0);
                check_val("abort_busy", 32'(bus.BUSY), 0);
                check_val("abort_done", 32'(bus.DONE), 0);
                check_val("abort_count", 32'(bus.COUNT), 32'(abort_after));
                @(negedge CLK);
                check_val("abort_no_done", 32'(bus.DONE), 0);
                return;
            end

            check_val("run_done_low", 32'(bus.DONE), 0);
            check_val("run_busy", 32'(bus.BUSY), 1);
            if (stall) begin
                check_val("hold_valid", 32'(bus.OUT_VALID), 1);
                check_val("hold_addr", 32'(bus.OUT_ADDR), 32'(h_a));
                check_val("hold_data", bus.OUT_DATA, h_d);
                check_val("hold_last", 32'(bus.OUT_LAST), 32'(h_l));
            end

            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 9) < 6);
                default: rdy = (vcyc < 7) ? (pat[vcyc] != 0) : 1'b1;
            endcase
            if (bus.OUT_VALID) vcyc++;
            bus.OUT_READY = rdy;

            if (bus.OUT_VALID && rdy) begin
                e = q.pop_front();
                check_val("word_addr", 32'(bus.OUT_ADDR), 32'(e.a));
                check_val("word_data", bus.OUT_DATA, e.d);
                check_val("word_last", 32'(bus.OUT_LAST), 32'(e.l));
                accepted++;
                stall = 1'b0;
            end else if (bus.OUT_VALID) begin
                stall = 1'b1;
                h_a = bus.OUT_ADDR; h_d = bus.OUT_DATA; h_l = bus.OUT_LAST;
            end else begin
                stall = 1'b0;
            end
            @(negedge CLK);
            cyc++;
        end
        bus.START = 1'b0;
        we3 = 1'b0;
        if (q.size() != 0) check_val("timeout_words_left", 32'(q.size()), 0);

        check_val("fin_done", 32'(bus.DONE), 1);
        check_val("fin_busy", 32'(bus.BUSY), 1);
        check_val("fin_valid", 32'(bus.OUT_VALID), 0);
        check_val("fin_count", 32'(bus.COUNT), 32'(m));
        bus.OUT_READY = 1'($urandom_range(0, 1));
        @(negedge CLK);
        check_val("idle_done", 32'(bus.DONE), 0);
        check_val("idle_busy", 32'(bus.BUSY), 0);
        check_val("idle_count", 32'(bus.COUNT), 32'(m));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0;
        RST = 1'b0;
        we3 = 1'b0; a3 = '0; wd3 = '0;
        bus.START = 1'b0; bus.FIRST_ADDR = '0; bus.LAST_ADDR = '0;
        bus.ABORT = 1'b0; bus.OUT_READY = 1'b0;
        #12;
        check_reset_outputs();
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < int'(NREG); i++) wr(i, 32'h1000 + 32'(i));

        run_dump(0, 31, 0, -1, 1'b0, 0, '0, 1'b0);
        run_dump(30, 1, 0, -1, 1'b0, 0, '0, 1'b0);
        run_dump(4, 6, 2, -1, 1'b0, 0, '0, 1'b0);
        run_dump(10, 14, 0, 2, 1'b0, 0, '0, 1'b0);
        run_dump(10, 14, 1, -1, 1'b0, 0, '0, 1'b0);
        run_dump(5, 5, 0, -1, 1'b1, 5, 32'hDEAD, 1'b0);
        run_dump(5, 5, 0, -1, 1'b0, 0, '0, 1'b0);
        run_dump(9, 8, 1, -1, 1'b0, 0, '0, 1'b0);

        // START together with ABORT in IDLE must not begin a dump
        @(negedge CLK);
        bus.START = 1'b1; bus.ABORT = 1'b1;
        bus.FIRST_ADDR = 5'd3; bus.LAST_ADDR = 5'd7;
        @(negedge CLK);
        bus.START = 1'b0; bus.ABORT = 1'b0;
        check_val("start_abort_busy", 32'(bus.BUSY), 0);
        check_val("start_abort_valid", 32'(bus.OUT_VALID), 0);

        // START while busy is ignored
        run_dump(0, 9, 1, -1, 1'b0, 0, '0, 1'b1);

        // Asynchronous reset in the middle of a dump
        do_start(0, 31);
        bus.OUT_READY = 1'b1;
        repeat (5) @(negedge CLK);
        bus.START = 1'b1; bus.FIRST_ADDR = 5'd20; bus.LAST_ADDR = 5'd21;
        #2 RST = 1'b0;
        #1 check_reset_outputs();
        bus.START = 1'b0;
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < 6; i++) wr($urandom_range(0, NREG - 1), $urandom);
        for (int t = 0; t < 8; t++)
            run_dump($urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1), 1, -1, 1'b0, 0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
